answer_round_ctrl: RTL
======================

// Module: answer_round_ctrl
// PURPOSE
//   Sequences one round of the number-guessing game around the random answer datapath.
//   Keeps a free-running 32-bit LFSR and draws an answer in 1..10 from it on start.
//   Accepts guesses over a valid/ready handshake and returns low/high/correct/invalid.
//   Counts remaining tries and ends the round in WIN or LOSE; sits between the CPU I/O and the display.
// PARAMETERS
//   SEED       32'hACE1_2468  LFSR value at reset; a value of 0 is replaced by 32'h0000_0001
//   MAX_TRIES  5              attempts per round, legal range 1..15
// PORTS
//   clock         in   1   rising-edge clock
//   reset         in   1   synchronous, active-high reset
//   seed_load     in   1   load LFSR from seed_value this cycle
//   seed_value    in   32  LFSR load value; 0 is loaded as 32'h0000_0001
//   start         in   1   begin a new round; honoured in IDLE, WIN and LOSE only
//   guess_valid   in   1   guess presented
//   guess         in   4   guessed number
//   guess_ready   out  1   controller accepts a guess this cycle
//   result_valid  out  1   one-cycle pulse, result is valid
//   result        out  2   00 = too low, 01 = too high, 10 = correct, 11 = invalid (outside 1..10)
//   tries_left    out  4   remaining attempts
//   busy          out  1   round in progress (PLAY)
//   done          out  1   round finished (WIN or LOSE)
//   won           out  1   1 in WIN
//   answer        out  4   latched answer; reads 0 unless in WIN or LOSE
// BEHAVIOUR
//   Reset: state = IDLE, lfsr = SEED (0 -> 1), answer_r = 0; every output = 0.
//   LFSR: Galois, taps x^32+x^22+x^2+x+1; steps every cycle when seed_load = 0.
//   seed_load = 1: next lfsr = seed_value (0 -> 1), in any state.
//     start is ignored in the same cycle; answer_r and the round are unaffected.
//   Answer draw: sum = lfsr[4:2] + lfsr[10:9] as a 4-bit zero-extended add (0..10).
//     answer_r = (sum == 0) ? 1 : sum, computed from the pre-step lfsr on the start edge.
//   IDLE -> PLAY: on start with seed_load = 0. Same edge: answer_r drawn, tries_left = MAX_TRIES.
//   PLAY: guess_ready = 1; a guess is accepted when guess_valid & guess_ready.
//   Results are registered: result_valid and result appear the cycle after acceptance.
//     guess == 0 or guess > 10 -> 11 (invalid); no try consumed; stay in PLAY.
//     guess < answer_r -> 00; guess > answer_r -> 01; tries_left decrements on the acceptance edge.
//     If tries_left reaches 0 on that edge -> LOSE.
//     guess == answer_r -> 10 -> WIN; tries_left unchanged.
//   State moves to WIN/LOSE on the same edge that registers the result.
//     guess_ready drops the cycle the result pulse is shown.
//   PLAY ignores start. guess_valid is ignored outside PLAY (guess_ready = 0).
//   WIN/LOSE: done = 1, won as stated, answer = answer_r; hold until start.
//     start there -> PLAY with a new draw and tries_left = MAX_TRIES, exactly as from IDLE.
//   busy = (state == PLAY); done = (state in WIN or LOSE). Outputs are registered or state-decoded.
//   Reset mid-round: round is abandoned next edge; all outputs return to reset values.
//   Back-to-back guesses on consecutive cycles are accepted; one result per accepted guess.
// TESTING
//   1 seed_load 0x0000_001C, then start -> answer_r 7.
//     Guesses 3, 9, 7 -> results 00, 01, 10; tries_left 5, 4, 3, 3; WIN, answer = 7.
//   2 seed_load 0x0000_0000, then start -> lfsr = 1, sum 0 -> answer 1.
//     Guess 1 -> result 10, won = 1.
//   3 seed_load 0x0000_061C, then start -> answer 10.
//     Five guesses of 2 -> five 00 results; tries_left reaches 0; LOSE, done = 1, won = 0, answer = 10.
//   4 In PLAY: guesses 0 and 12 -> result 11 each; tries_left unchanged.
//     start pulsed in PLAY -> ignored (answer_r and tries_left unchanged).
//   5 seed_load and start in the same cycle -> no round starts; state stays IDLE.
//     Next-cycle start draws from seed_value.
//   6 reset asserted mid-PLAY after one guess -> next cycle state IDLE.
//     All outputs 0; lfsr = SEED; next start restores tries_left = 5.

Source files
------------

// File: rtl/answer_round_ctrl.sv
// ---------------------------------------------------------------------------
// answer_round_ctrl
//   Runs one round of the number-guessing game. A free-running 32-bit Galois
//   LFSR supplies an answer in 1..10 when a round starts. Guesses come in over
//   a valid/ready handshake. Each accepted guess produces one registered
//   result: too low, too high, correct or invalid. The block counts the
//   remaining tries and ends the round in WIN or LOSE.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous active-high reset
//   i_seed_load    load the LFSR from i_seed_value (0 is loaded as 1)
//   i_seed_value   LFSR load value
//   i_start        start a round (honoured in IDLE/WIN/LOSE, not with seed_load)
//   i_guess_valid  guess presented
//   i_guess        guessed number
//   o_guess_ready  guess accepted this cycle (PLAY)
//   o_result_valid one-cycle pulse, the cycle after acceptance
//   o_result       00 low, 01 high, 10 correct, 11 invalid
//   o_tries_left   remaining attempts
//   o_busy         round in progress
//   o_done         round finished (WIN or LOSE)
//   o_won          round won
//   o_answer       latched answer, visible only in WIN/LOSE
// ---------------------------------------------------------------------------
module answer_round_ctrl #(
    parameter logic [31:0] SEED      = 32'hACE1_2468,
    parameter int          MAX_TRIES = 5
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_seed_load,
    input  logic [31:0] i_seed_value,
    input  logic        i_start,
    input  logic        i_guess_valid,
    input  logic [3:0]  i_guess,
    output logic        o_guess_ready,
    output logic        o_result_valid,
    output logic [1:0]  o_result,
    output logic [3:0]  o_tries_left,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_won,
    output logic [3:0]  o_answer
);

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    localparam logic [31:0] SEED_NZ   = (SEED == 32'd0) ? 32'd1 : SEED;
    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [3:0]  TRIES_INIT = 4'(MAX_TRIES);

    localparam logic [1:0] RES_LOW     = 2'b00;
    localparam logic [1:0] RES_HIGH    = 2'b01;
    localparam logic [1:0] RES_CORRECT = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_WIN,
        S_LOSE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_lfsr, w_lfsr_nxt;
    logic [3:0]  r_answer, w_answer_nxt;
    logic [3:0]  r_tries, w_tries_nxt;
    logic        r_result_valid, w_result_valid_nxt;
    logic [1:0]  r_result, w_result_nxt;

    logic [3:0]  w_draw_sum;
    logic [3:0]  w_draw;
    logic        w_start_ok;
    logic        w_accept;
    logic        w_invalid;

    // The answer comes from the LFSR value present on the start edge, before
    // that edge steps it.
    always_comb begin
        w_draw_sum = {1'b0, r_lfsr[4:2]} + {2'b00, r_lfsr[10:9]};
        w_draw     = (w_draw_sum == 4'd0) ? 4'd1 : w_draw_sum;
    end

    always_comb begin
        if (i_seed_load)
            w_lfsr_nxt = (i_seed_value == 32'd0) ? 32'd1 : i_seed_value;
        else
            w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'd0);
    end

    // A seed load in the same cycle suppresses start.
    assign w_start_ok = i_start && !i_seed_load && (r_state != S_PLAY);
    assign w_accept   = i_guess_valid && (r_state == S_PLAY);
    assign w_invalid  = (i_guess == 4'd0) || (i_guess > 4'd10);

    always_comb begin
        w_state_nxt        = r_state;
        w_answer_nxt       = r_answer;
        w_tries_nxt        = r_tries;
        w_result_valid_nxt = 1'b0;
        w_result_nxt       = r_result;
        case (r_state)
            S_PLAY: begin
                if (w_accept) begin
                    w_result_valid_nxt = 1'b1;
                    if (w_invalid) begin
                        w_result_nxt = RES_INVALID;
                    end else if (i_guess == r_answer) begin
                        w_result_nxt = RES_CORRECT;
                        w_state_nxt  = S_WIN;
                    end else begin
                        w_result_nxt = (i_guess < r_answer) ? RES_LOW : RES_HIGH;
                        w_tries_nxt  = r_tries - 4'd1;
                        if (r_tries == 4'd1)
                            w_state_nxt = S_LOSE;
                    end
                end
            end
            default: begin
                if (w_start_ok) begin
                    w_state_nxt  = S_PLAY;
                    w_answer_nxt = w_draw;
                    w_tries_nxt  = TRIES_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_lfsr         <= SEED_NZ;
            r_answer       <= 4'd0;
            r_tries        <= 4'd0;
            r_result_valid <= 1'b0;
            r_result       <= 2'b00;
        end else begin
            r_state        <= w_state_nxt;
            r_lfsr         <= w_lfsr_nxt;
            r_answer       <= w_answer_nxt;
            r_tries        <= w_tries_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_result       <= w_result_nxt;
        end
    end

    assign o_guess_ready  = (r_state == S_PLAY);
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_tries_left   = r_tries;
    assign o_busy         = (r_state == S_PLAY);
    assign o_done         = (r_state == S_WIN) || (r_state == S_LOSE);
    assign o_won          = (r_state == S_WIN);
    assign o_answer       = o_done ? r_answer : 4'd0;

endmodule
